// File: rtl/program_counter_stack.sv
// Program counter with clock enable, absolute jump and a hardware return-address stack.
// Optional macro REL_JUMP_EN adds a 'rel' input for PC-relative jump/call targets.
module program_counter_stack #(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter int                SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
`ifdef REL_JUMP_EN
    input  logic              rel,
`endif
    input  logic [ADDR_W-1:0] jp_addr,
    output logic [ADDR_W-1:0] cnt,
    output logic [SP_W-1:0]   sp,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    localparam int              IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0] cntInc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] popData;
    logic [IDX_W-1:0]  pushIdx;
    logic [IDX_W-1:0]  popIdx;
    logic              pushEn;

    assign cntInc  = cnt_q + ADDR_W'(1);
    assign pushIdx = IDX_W'(sp_q);
    assign popIdx  = IDX_W'(sp_q - SP_W'(1));
    assign popData = stack_q[popIdx];

    // Two's-complement add gives the signed relative target modulo 2^ADDR_W.
`ifdef REL_JUMP_EN
    assign target = rel ? (cnt_q + jp_addr) : jp_addr;
`else
    assign target = jp_addr;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        sp_d   = sp_q;
        err_d  = err_q;
        pushEn = 1'b0;
        if (en) begin
            if (ret) begin
                if (sp_q != '0) begin
                    cnt_d = popData;
                    sp_d  = sp_q - SP_W'(1);
                end else begin
                    cnt_d = cntInc;
                    err_d = 1'b1;
                end
            end else if (call) begin
                // A call into a full stack is dropped and behaves like a plain increment.
                if (sp_q != SP_FULL) begin
                    pushEn = 1'b1;
                    cnt_d  = target;
                    sp_d   = sp_q + SP_W'(1);
                end else begin
                    cnt_d = cntInc;
                    err_d = 1'b1;
                end
            end else if (jump) begin
                cnt_d = target;
            end else begin
                cnt_d = cntInc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RESET_ADDR;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack entries carry no reset; only slots below sp are ever read.
    always_ff @(posedge clk) begin
        if (!rst && pushEn) begin
            stack_q[pushIdx] <= cntInc;
        end
    end

    assign cnt         = cnt_q;
    assign sp          = sp_q;
    assign stack_err   = err_q;
    assign stack_full  = (sp_q == SP_FULL);
    assign stack_empty = (sp_q == '0);

endmodule

// File: tb/tb_program_counter_stack.sv
// Self-checking bench for program_counter_stack: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_program_counter_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       jump;
    logic       call;
    logic       ret;
`ifdef REL_JUMP_EN
    logic       rel;
`endif
    logic [7:0] jpAddr;
    logic [7:0] cnt;
    logic [1:0] sp;
    logic       stackFull;
    logic       stackEmpty;
    logic       stackErr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic       en;
        logic       jump;
        logic       call;
        logic       ret;
        logic       rel;
        logic [7:0] jp;
        logic [7:0] expCnt;
        logic [1:0] expSp;
        logic       expErr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    program_counter_stack #(
        .ADDR_W     (8),
        .STACK_DEPTH(2),
        .RESET_ADDR (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .jump       (jump),
        .call       (call),
        .ret        (ret),
`ifdef REL_JUMP_EN
        .rel        (rel),
`endif
        .jp_addr    (jpAddr),
        .cnt        (cnt),
        .sp         (sp),
        .stack_full (stackFull),
        .stack_empty(stackEmpty),
        .stack_err  (stackErr)
    );

    function automatic vec_t mk(string n, logic e, logic j, logic c, logic r, logic [7:0] jp,
                                logic [7:0] ec, logic [1:0] es, logic ee);
        vec_t v;
        v.name = n; v.en = e; v.jump = j; v.call = c; v.ret = r; v.rel = 1'b0;
        v.jp = jp; v.expCnt = ec; v.expSp = es; v.expErr = ee;
        return v;
    endfunction

    // Drive at a falling edge; the next falling edge follows exactly one rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic j, input logic c,
                                 input logic rt, input logic rl, input logic [7:0] jp);
        rst = r; en = e; jump = j; call = c; ret = rt; jpAddr = jp;
`ifdef REL_JUMP_EN
        rel = rl;
`else
        if (rl) $display("[TB] note: rel requested but feature not built");
`endif
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eCnt, input logic [1:0] eSp,
                               input logic eErr);
        total++;
        if (cnt !== eCnt || sp !== eSp || stackFull !== (eSp == 2'd2) ||
            stackEmpty !== (eSp == 2'd0) || stackErr !== eErr) begin
            bad++;
            $display("[TB] FAIL %s: got cnt=%h sp=%0d full=%b empty=%b err=%b, want cnt=%h sp=%0d full=%b empty=%b err=%b",
                     name, cnt, sp, stackFull, stackEmpty, stackErr,
                     eCnt, eSp, (eSp == 2'd2), (eSp == 2'd0), eErr);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        checkOutput("reset", 8'h00, 2'd0, 1'b0);
    endtask

    int         mCnt;
    int         mStack[$];
    bit         mErr;
    logic       rR, rE, rJ, rC, rT, rL;
    logic [7:0] rJp;
    int         tgt;

    initial begin
        rst = 1'b1; en = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; jpAddr = 8'h00;
`ifdef REL_JUMP_EN
        rel = 1'b0;
`endif
        @(negedge clk);
        doReset();

        for (int i = 1; i <= 300; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            checkOutput("idle_count", 8'(i % 256), 2'd0, 1'b0);
        end

        vecs.push_back(mk("jump_0x10",      1, 1, 0, 0, 8'h10, 8'h10, 0, 0));
        vecs.push_back(mk("jump_0x80",      1, 1, 0, 0, 8'h80, 8'h80, 0, 0));
        vecs.push_back(mk("inc_after_jump", 1, 0, 0, 0, 8'h00, 8'h81, 0, 0));
        vecs.push_back(mk("stall_jump",     0, 1, 0, 0, 8'h22, 8'h81, 0, 0));
        vecs.push_back(mk("stall_call",     0, 0, 1, 0, 8'h23, 8'h81, 0, 0));
        vecs.push_back(mk("stall_ret",      0, 0, 0, 1, 8'h00, 8'h81, 0, 0));
        vecs.push_back(mk("jump_0x05",      1, 1, 0, 0, 8'h05, 8'h05, 0, 0));
        vecs.push_back(mk("call_0x40",      1, 0, 1, 0, 8'h40, 8'h40, 1, 0));
        vecs.push_back(mk("inc_in_sub",     1, 0, 0, 0, 8'h00, 8'h41, 1, 0));
        vecs.push_back(mk("call_0x60",      1, 0, 1, 0, 8'h60, 8'h60, 2, 0));
        vecs.push_back(mk("ret_to_0x42",    1, 0, 0, 1, 8'h00, 8'h42, 1, 0));
        vecs.push_back(mk("ret_to_0x06",    1, 0, 0, 1, 8'h00, 8'h06, 0, 0));
        vecs.push_back(mk("jump_0x32",      1, 1, 0, 0, 8'h32, 8'h32, 0, 0));
        vecs.push_back(mk("call_0x70",      1, 0, 1, 0, 8'h70, 8'h70, 1, 0));
        vecs.push_back(mk("ret_call_jump",  1, 1, 1, 1, 8'h99, 8'h33, 0, 0));
        vecs.push_back(mk("jump_0xff",      1, 1, 0, 0, 8'hFF, 8'hFF, 0, 0));
        vecs.push_back(mk("call_wrap_push", 1, 0, 1, 0, 8'h10, 8'h10, 1, 0));
        vecs.push_back(mk("ret_to_0x00",    1, 0, 0, 1, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("jump_0x5f",      1, 1, 0, 0, 8'h5F, 8'h5F, 0, 0));
        vecs.push_back(mk("call_0xa0",      1, 0, 1, 0, 8'hA0, 8'hA0, 1, 0));
        vecs.push_back(mk("jump_0x60",      1, 1, 0, 0, 8'h60, 8'h60, 1, 0));
        vecs.push_back(mk("call_fill",      1, 0, 1, 0, 8'h61, 8'h61, 2, 0));
        vecs.push_back(mk("call_overflow",  1, 0, 1, 0, 8'h90, 8'h62, 2, 1));
        vecs.push_back(mk("stall_err_hold", 0, 0, 0, 1, 8'h00, 8'h62, 2, 1));
        vecs.push_back(mk("ret_to_0x61",    1, 0, 0, 1, 8'h00, 8'h61, 1, 1));
        vecs.push_back(mk("ret_to_0x60",    1, 0, 0, 1, 8'h00, 8'h60, 0, 1));
        vecs.push_back(mk("ret_underflow",  1, 0, 0, 1, 8'h00, 8'h61, 0, 1));
        vecs.push_back(mk("call_jump",      1, 1, 1, 0, 8'h44, 8'h44, 1, 1));
        vecs.push_back(mk("err_sticky",     1, 0, 0, 0, 8'h00, 8'h45, 1, 1));

        doReset();
        foreach (vecs[i]) begin
            applyStimulus(1'b0, vecs[i].en, vecs[i].jump, vecs[i].call, vecs[i].ret,
                          vecs[i].rel, vecs[i].jp);
            checkOutput(vecs[i].name, vecs[i].expCnt, vecs[i].expSp, vecs[i].expErr);
        end

        // Reset while the stack is full and the error flag is set, with a request pending.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20);
        checkOutput("seq_call_full", 8'h20, 2'd2, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("seq_rst_mid", 8'h00, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("seq_underflow", 8'h01, 2'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("seq_err_kept", 8'h02, 2'd0, 1'b1);

`ifdef REL_JUMP_EN
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
        checkOutput("rel_setup_10", 8'h10, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hF0);
        checkOutput("rel_jump_back", 8'h00, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE);
        checkOutput("rel_setup_fe", 8'hFE, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05);
        checkOutput("rel_jump_wrap", 8'h03, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFE);
        checkOutput("rel_call", 8'h01, 2'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40);
        checkOutput("rel_ret_ignored", 8'h04, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40);
        checkOutput("rel_inc_ignored", 8'h05, 2'd0, 1'b0);
`endif

        // Randomized traffic; the model treats the stack as a queue with push_back/pop_back.
        doReset();
        mCnt = 0;
        mStack.delete();
        mErr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rR  = ($urandom_range(0, 99) == 0);
            rE  = ($urandom_range(0, 7) != 0);
            rJ  = ($urandom_range(0, 3) == 0);
            rC  = ($urandom_range(0, 4) == 0);
            rT  = ($urandom_range(0, 4) == 0);
            rJp = 8'($urandom_range(0, 255));
`ifdef REL_JUMP_EN
            rL  = ($urandom_range(0, 1) == 1);
`else
            rL  = 1'b0;
`endif
            applyStimulus(rR, rE, rJ, rC, rT, rL, rJp);

            tgt = int'(rJp);
            if (rL) tgt = (mCnt + int'($signed(rJp))) & 255;
            if (rR) begin
                mCnt = 0;
                mStack.delete();
                mErr = 1'b0;
            end else if (rE) begin
                if (rT) begin
                    if (mStack.size() > 0) mCnt = mStack.pop_back();
                    else begin mCnt = (mCnt + 1) & 255; mErr = 1'b1; end
                end else if (rC) begin
                    if (mStack.size() < 2) begin
                        mStack.push_back((mCnt + 1) & 255);
                        mCnt = tgt;
                    end else begin
                        mCnt = (mCnt + 1) & 255;
                        mErr = 1'b1;
                    end
                end else if (rJ) begin
                    mCnt = tgt;
                end else begin
                    mCnt = (mCnt + 1) & 255;
                end
            end
            checkOutput("random", 8'(mCnt), 2'(mStack.size()), mErr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
